// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
// State encodings match the pipeline's DivFree/DivByZero/DivOn/DivEnd values.
package div_unit_pkg;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU in EX.
// result_o = {remainder, quotient}; one quotient bit per cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
    return (~v) + DATA_W'(1);
  endfunction

  div_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [2*DATA_W:0]     r_work, w_work_nxt;
  logic [DATA_W-1:0]     r_divisor, w_divisor_nxt;
  logic                  r_signed, w_signed_nxt;
  logic                  r_sign1, w_sign1_nxt;
  logic                  r_sign2, w_sign2_nxt;
  logic [2*DATA_W-1:0]   r_result, w_result_nxt;
  logic                  r_ready, w_ready_nxt;

  logic [DATA_W-1:0]     w_mag1, w_mag2;
  logic [DATA_W+1:0]     w_part;
  logic                  w_ge;
  logic [DATA_W:0]       w_diff;
  logic [2*DATA_W:0]     w_step;
  logic [DATA_W-1:0]     w_quo_fix, w_rem_fix;

  assign w_mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? neg(opdata1_i) : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? neg(opdata2_i) : opdata2_i;

  // Trial subtract of {rem, quo msb} against the divisor; rem never exceeds 32 bits,
  // so the top work bit only participates in the compare.
  assign w_part = r_work[2*DATA_W:DATA_W-1];
  assign w_ge   = w_part >= {2'b00, r_divisor};
  assign w_diff = w_part[DATA_W:0] - {1'b0, r_divisor};
  assign w_step = w_ge ? {w_diff, r_work[DATA_W-2:0], 1'b1}
                       : {r_work[2*DATA_W-1:0], 1'b0};

  assign w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? neg(w_step[DATA_W-1:0])
                                                       : w_step[DATA_W-1:0];
  assign w_rem_fix = (r_signed && r_sign1) ? neg(w_step[2*DATA_W-1:DATA_W])
                                           : w_step[2*DATA_W-1:DATA_W];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_signed_nxt  = r_signed;
    w_sign1_nxt   = r_sign1;
    w_sign2_nxt   = r_sign2;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    case (r_state)
      DIV_FREE: begin
        w_ready_nxt  = 1'b0;
        w_result_nxt = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DIV_BYZERO;
          end else begin
            w_state_nxt   = DIV_ON;
            w_cnt_nxt     = '0;
            w_work_nxt    = {{(DATA_W+1){1'b0}}, w_mag1};
            w_divisor_nxt = w_mag2;
            w_signed_nxt  = signed_div_i;
            w_sign1_nxt   = opdata1_i[DATA_W-1];
            w_sign2_nxt   = opdata2_i[DATA_W-1];
          end
        end
      end
      DIV_BYZERO: begin
        if (annul_i) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_state_nxt = DIV_END;
          w_work_nxt  = '0;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            w_state_nxt = DIV_END;
            w_work_nxt  = {1'b0, w_rem_fix, w_quo_fix};
          end else begin
            w_work_nxt  = w_step;
          end
        end
      end
      DIV_END: begin
        w_ready_nxt  = 1'b1;
        w_result_nxt = r_work[2*DATA_W-1:0];
        if (!start_i) w_state_nxt = DIV_FREE;
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_signed  <= w_signed_nxt;
      r_sign1   <= w_sign1_nxt;
      r_sign2   <= w_sign2_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule
